// File: rtl/mem_pkg.sv
// Shared memory-system types and the slave address map used by the bus
// interconnect and its address decoder.
package mem_pkg;

  typedef logic [31:0] RV32I_OPERAND_t;
  typedef logic [3:0]  BUS_BE_t;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_ACCESS,
    BUS_RESP,
    BUS_ERR
  } BUS_STATE_t;

  localparam int N_SLV_MAX = 8;
  localparam int SEL_W     = 3;

  // GPIO aliases the top of the ROM window, so ROM shadows it there.
  // Unused entries carry a base with low bits set, which never matches.
  localparam RV32I_OPERAND_t SLV_BASE [N_SLV_MAX] = '{
    32'h0040_0000,
    32'h1001_0000,
    32'h007F_0000,
    32'hFFFF_0000,
    32'hFFFF_FFFF,
    32'hFFFF_FFFF,
    32'hFFFF_FFFF,
    32'hFFFF_FFFF
  };

  localparam RV32I_OPERAND_t SLV_MASK [N_SLV_MAX] = '{
    32'hFFC0_0000,
    32'hFFFF_0000,
    32'hFFFF_0000,
    32'hFFFF_FF00,
    32'hFFFF_FFFF,
    32'hFFFF_FFFF,
    32'hFFFF_FFFF,
    32'hFFFF_FFFF
  };

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational base/mask decoder: match flag, selected slave index and the
// word offset into that slave.
module bus_addr_decoder
  import mem_pkg::*;
#(
  parameter int N_SLV = 4
) (
  input  logic [31:0]      i_addr,
  output logic             o_match,
  output logic [SEL_W-1:0] o_sel,
  output logic [31:0]      o_offset
);

  logic [31:0] w_aligned;
  logic [31:0] w_diff;

  assign w_aligned = {i_addr[31:2], 2'b00};

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    o_match = 1'b0;
    o_sel   = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((w_aligned & SLV_MASK[i]) == SLV_BASE[i]) begin
        o_match = 1'b1;
        o_sel   = SEL_W'(i);
      end
    end
  end

  assign w_diff   = i_addr - SLV_BASE[o_sel];
  assign o_offset = {2'b00, w_diff[31:2]};

endmodule

// File: rtl/bus_interconnect.sv
// Single-master to N_SLV-slave interconnect with request/ready handshake,
// per-slave wait states, decode errors and a wait-state timeout.
module bus_interconnect
  import mem_pkg::*;
#(
  parameter int          N_SLV      = 4,
  parameter int          TIMEOUT    = 16,
  parameter logic [31:0] ERR_RDDATA = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bus_req,
  input  logic [31:0]          bus_addr,
  input  logic [31:0]          bus_wrdata,
  input  logic                 bus_wren,
  input  logic [3:0]           bus_be,
  output logic [31:0]          bus_rddata,
  output logic                 bus_ready,
  output logic                 bus_err,
  output logic [31:0]          slv_addr,
  output logic [31:0]          slv_wrdata,
  output logic [3:0]           slv_be,
  output logic [N_SLV-1:0]     slv_req,
  output logic [N_SLV-1:0]     slv_wren,
  input  logic [N_SLV*32-1:0]  slv_rddata,
  input  logic [N_SLV-1:0]     slv_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  BUS_STATE_t       r_state;
  logic [31:0]      r_offset;
  logic [31:0]      r_wrdata;
  BUS_BE_t          r_be;
  logic             r_wren;
  logic [SEL_W-1:0] r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_rddata;
  logic             r_ready;
  logic             r_err;

  logic                 w_match;
  logic [SEL_W-1:0]     w_sel;
  logic [31:0]          w_offset;
  logic [N_SLV_MAX-1:0] w_readyExt;
  logic [31:0]          w_rdArr [N_SLV_MAX];

  bus_addr_decoder #(.N_SLV(N_SLV)) u_decoder (
    .i_addr   (bus_addr),
    .o_match  (w_match),
    .o_sel    (w_sel),
    .o_offset (w_offset)
  );

  // Widen the slave-side vectors to N_SLV_MAX so r_sel can index them directly.
  assign w_readyExt = N_SLV_MAX'(slv_ready);

  always_comb begin
    for (int i = 0; i < N_SLV_MAX; i++) w_rdArr[i] = '0;
    for (int i = 0; i < N_SLV; i++) w_rdArr[i] = slv_rddata[i*32 +: 32];
  end

  // Derived from the state register so an async reset drops it immediately.
  always_comb begin
    slv_req = '0;
    for (int i = 0; i < N_SLV; i++)
      slv_req[i] = (r_state == BUS_ACCESS) && (r_sel == SEL_W'(i));
  end

  assign slv_wren   = slv_req & {N_SLV{r_wren}};
  assign slv_addr   = r_offset;
  assign slv_wrdata = r_wrdata;
  assign slv_be     = r_be;
  assign bus_rddata = r_rddata;
  assign bus_ready  = r_ready;
  assign bus_err    = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= BUS_IDLE;
      r_offset <= '0;
      r_wrdata <= '0;
      r_be     <= '0;
      r_wren   <= 1'b0;
      r_sel    <= '0;
      r_cnt    <= '0;
      r_rddata <= ERR_RDDATA;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        BUS_IDLE: begin
          if (bus_req) begin
            r_offset <= w_offset;
            r_wrdata <= bus_wrdata;
            r_be     <= bus_be;
            r_wren   <= bus_wren;
            r_sel    <= w_sel;
            r_cnt    <= '0;
            if (w_match) begin
              r_state <= BUS_ACCESS;
            end else begin
              r_state  <= BUS_ERR;
              r_ready  <= 1'b1;
              r_err    <= 1'b1;
              r_rddata <= ERR_RDDATA;
            end
          end
        end
        BUS_ACCESS: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_readyExt[r_sel]) begin
            if (!r_wren) r_rddata <= w_rdArr[r_sel];
            r_ready <= 1'b1;
            r_state <= BUS_RESP;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state  <= BUS_ERR;
            r_ready  <= 1'b1;
            r_err    <= 1'b1;
            r_rddata <= ERR_RDDATA;
          end
        end
        BUS_RESP: r_state <= BUS_IDLE;
        BUS_ERR:  r_state <= BUS_IDLE;
        default:  r_state <= BUS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed self-checking bench for bus_interconnect with the default
// four-slave map, TIMEOUT=16 and ERR_RDDATA=0.
module tb_bus_interconnect;

  logic         clk;
  logic         rst;
  logic         bus_req;
  logic [31:0]  bus_addr;
  logic [31:0]  bus_wrdata;
  logic         bus_wren;
  logic [3:0]   bus_be;
  logic [31:0]  bus_rddata;
  logic         bus_ready;
  logic         bus_err;
  logic [31:0]  slv_addr;
  logic [31:0]  slv_wrdata;
  logic [3:0]   slv_be;
  logic [3:0]   slv_req;
  logic [3:0]   slv_wren;
  logic [127:0] slv_rddata;
  logic [3:0]   slv_ready;

  int total = 0;
  int bad   = 0;

  bus_interconnect #(
    .N_SLV      (4),
    .TIMEOUT    (16),
    .ERR_RDDATA (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_wrdata (bus_wrdata),
    .bus_wren   (bus_wren),
    .bus_be     (bus_be),
    .bus_rddata (bus_rddata),
    .bus_ready  (bus_ready),
    .bus_err    (bus_err),
    .slv_addr   (slv_addr),
    .slv_wrdata (slv_wrdata),
    .slv_be     (slv_be),
    .slv_req    (slv_req),
    .slv_wren   (slv_wren),
    .slv_rddata (slv_rddata),
    .slv_ready  (slv_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [31:0] addr,
                               input logic wr, input logic [31:0] data,
                               input logic [3:0] be);
    bus_req    = req;
    bus_addr   = addr;
    bus_wren   = wr;
    bus_wrdata = data;
    bus_be     = be;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int reqCycles;
    int earlyReady;

    rst        = 1'b1;
    slv_rddata = '0;
    slv_ready  = '0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);

    // Reset state
    tick();
    tick();
    checkOutput("rst_ready", 32'(bus_ready), 32'h0);
    checkOutput("rst_err", 32'(bus_err), 32'h0);
    checkOutput("rst_rddata", bus_rddata, 32'h0);
    checkOutput("rst_slv_req", 32'(slv_req), 32'h0);
    checkOutput("rst_slv_wren", 32'(slv_wren), 32'h0);
    rst = 1'b0;
    tick();

    // ROM read, zero wait states
    slv_rddata[31:0] = 32'h1234_5678;
    slv_ready        = 4'b0001;
    applyStimulus(1'b1, 32'h0040_0008, 1'b0, 32'h0, 4'hF);
    tick();
    bus_req = 1'b0;
    checkOutput("rom_c1_slv_req", 32'(slv_req), 32'h1);
    checkOutput("rom_c1_slv_wren", 32'(slv_wren), 32'h0);
    checkOutput("rom_c1_slv_addr", slv_addr, 32'h2);
    checkOutput("rom_c1_ready", 32'(bus_ready), 32'h0);
    tick();
    checkOutput("rom_c2_ready", 32'(bus_ready), 32'h1);
    checkOutput("rom_c2_err", 32'(bus_err), 32'h0);
    checkOutput("rom_c2_rddata", bus_rddata, 32'h1234_5678);
    checkOutput("rom_c2_slv_req", 32'(slv_req), 32'h0);
    slv_ready = 4'b0000;
    tick();
    checkOutput("rom_c3_ready", 32'(bus_ready), 32'h0);
    checkOutput("rom_c3_hold", bus_rddata, 32'h1234_5678);

    // RAM write, three wait states
    slv_rddata[63:32] = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 32'h1001_0010, 1'b1, 32'hAABB_CCDD, 4'b0011);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h5555_5555, 4'hF);
    checkOutput("ram_c1_slv_req", 32'(slv_req), 32'h2);
    checkOutput("ram_c1_slv_wren", 32'(slv_wren), 32'h2);
    checkOutput("ram_c1_slv_be", 32'(slv_be), 32'h3);
    checkOutput("ram_c1_slv_addr", slv_addr, 32'h4);
    checkOutput("ram_c1_wrdata", slv_wrdata, 32'hAABB_CCDD);
    tick();
    checkOutput("ram_c2_ready", 32'(bus_ready), 32'h0);
    tick();
    checkOutput("ram_c3_ready", 32'(bus_ready), 32'h0);
    tick();
    checkOutput("ram_c4_ready", 32'(bus_ready), 32'h0);
    checkOutput("ram_c4_slv_req", 32'(slv_req), 32'h2);
    slv_ready = 4'b0010;
    tick();
    slv_ready = 4'b0000;
    checkOutput("ram_c5_ready", 32'(bus_ready), 32'h1);
    checkOutput("ram_c5_err", 32'(bus_err), 32'h0);
    checkOutput("ram_c5_rddata", bus_rddata, 32'h1234_5678);
    tick();

    // Unmapped address gives a decode error in cycle 1
    applyStimulus(1'b1, 32'h2000_0000, 1'b0, 32'h0, 4'hF);
    tick();
    bus_req = 1'b0;
    checkOutput("dec_c1_ready", 32'(bus_ready), 32'h1);
    checkOutput("dec_c1_err", 32'(bus_err), 32'h1);
    checkOutput("dec_c1_rddata", bus_rddata, 32'h0);
    checkOutput("dec_c1_slv_req", 32'(slv_req), 32'h0);
    tick();
    checkOutput("dec_c2_ready", 32'(bus_ready), 32'h0);

    // Timeout with a stray ready from a non-selected slave
    reqCycles  = 0;
    earlyReady = 0;
    applyStimulus(1'b1, 32'h1001_0000, 1'b0, 32'h0, 4'hF);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (slv_req == 4'b0010) reqCycles++;
      if (bus_ready) earlyReady++;
      if (k == 1) bus_req = 1'b0;
      if (k == 5) slv_ready = 4'b0001;
      if (k == 6) slv_ready = 4'b0000;
    end
    checkOutput("to_req_cycles", 32'(reqCycles), 32'd16);
    checkOutput("to_early_ready", 32'(earlyReady), 32'd0);
    tick();
    checkOutput("to_ready", 32'(bus_ready), 32'h1);
    checkOutput("to_err", 32'(bus_err), 32'h1);
    checkOutput("to_rddata", bus_rddata, 32'h0);
    checkOutput("to_slv_req", 32'(slv_req), 32'h0);
    tick();

    // Reset asserted mid-access aborts without a response
    slv_rddata[31:0] = 32'hCAFE_0001;
    applyStimulus(1'b1, 32'h0040_0004, 1'b0, 32'h0, 4'hF);
    tick();
    bus_req = 1'b0;
    checkOutput("rst_mid_req_before", 32'(slv_req), 32'h1);
    #2 rst = 1'b1;
    #1 checkOutput("rst_mid_req_drop", 32'(slv_req), 32'h0);
    tick();
    checkOutput("rst_mid_ready", 32'(bus_ready), 32'h0);
    rst = 1'b0;
    tick();
    checkOutput("rst_after_ready", 32'(bus_ready), 32'h0);
    slv_ready = 4'b0001;
    applyStimulus(1'b1, 32'h0040_000C, 1'b0, 32'h0, 4'hF);
    tick();
    bus_req = 1'b0;
    checkOutput("post_rst_slv_addr", slv_addr, 32'h3);
    tick();
    checkOutput("post_rst_ready", 32'(bus_ready), 32'h1);
    checkOutput("post_rst_rddata", bus_rddata, 32'hCAFE_0001);
    tick();

    // Overlap of entries 0 and 2 resolves to slave 0; back-to-back reads
    slv_rddata[31:0]  = 32'h1111_1111;
    slv_rddata[95:64] = 32'h2222_2222;
    slv_ready         = 4'b0101;
    applyStimulus(1'b1, 32'h007F_0010, 1'b0, 32'h0, 4'hF);
    tick();
    applyStimulus(1'b1, 32'h0040_0020, 1'b0, 32'h0, 4'h0);
    checkOutput("ovl_c1_slv_req", 32'(slv_req), 32'h1);
    checkOutput("ovl_c1_slv_addr", slv_addr, 32'h000F_C004);
    tick();
    checkOutput("ovl_c2_ready", 32'(bus_ready), 32'h1);
    checkOutput("ovl_c2_rddata", bus_rddata, 32'h1111_1111);
    slv_rddata[31:0] = 32'h3333_3333;
    tick();
    checkOutput("b2b_c3_ready", 32'(bus_ready), 32'h0);
    tick();
    bus_req = 1'b0;
    checkOutput("b2b_c4_slv_req", 32'(slv_req), 32'h1);
    checkOutput("b2b_c4_slv_addr", slv_addr, 32'h8);
    checkOutput("b2b_c4_slv_be", 32'(slv_be), 32'h0);
    tick();
    checkOutput("b2b_c5_ready", 32'(bus_ready), 32'h1);
    checkOutput("b2b_c5_rddata", bus_rddata, 32'h3333_3333);
    slv_ready = 4'b0000;
    tick();
    checkOutput("b2b_c6_ready", 32'(bus_ready), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_interconnect.md
Name: bus_interconnect

Overview:
- Parametrised successor of the single-cycle memory controller.
- Decodes one master bus (core load/store port) onto N_SLV memory-mapped slaves (ROM, RAM, GPIO, UART, ...) using a package-defined base/mask address map.
- Adds byte enables, a request/ready handshake with per-slave wait states, a registered response, decode-error reporting and a wait-state timeout.
- Sits between the datapath's memory stage and the slave memories/peripherals.

Parameters:
- N_SLV, 4, number of slave ports (1..8); slave i uses SLV_BASE[i]/SLV_MASK[i] from mem_pkg.
- TIMEOUT, 16, maximum ACCESS cycles waiting for slv_ready before an error response (>=2).
- ERR_RDDATA, 32'h0000_0000, read data returned on any error response.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- bus_req  in  1  master request; held high until bus_ready.
- bus_addr  in  32  byte address (RV32I_OPERAND_t).
- bus_wrdata  in  32  write data.
- bus_wren  in  1  1 = write, 0 = read.
- bus_be  in  4  byte enables; bit k = byte lane k.
- bus_rddata  out  32  registered read data, valid when bus_ready=1.
- bus_ready  out  1  one-cycle response pulse.
- bus_err  out  1  qualifies bus_ready: decode or timeout error.
- slv_addr  out  32  word offset: (bus_addr - SLV_BASE[sel]) >> 2.
- slv_wrdata  out  32  latched write data.
- slv_be  out  4  latched byte enables.
- slv_req  out  N_SLV  one-hot request to the selected slave.
- slv_wren  out  N_SLV  one-hot write strobe, qualified by slv_req.
- slv_rddata  in  N_SLV*32  slave read data; slice i belongs to slave i.
- slv_ready  in  N_SLV  slave i completes its access.

Behaviour:
- Reset (async, immediate):
  - State = IDLE.
  - All outputs = 0, except bus_rddata = ERR_RDDATA.
  - Latched address, data, byte enables, select and counter cleared.
  - Reset mid-access drops slv_req combinationally; no response is issued for the aborted transaction.
- Decode (combinational):
  - Slave i matches when (bus_addr & SLV_MASK[i]) == SLV_BASE[i].
  - Lowest index wins on overlap.
  - No match = decode error.
  - bus_addr[1:0] is ignored.
- States: IDLE, ACCESS, RESP, ERR.
- IDLE:
  - On bus_req=1, latch addr offset, wrdata, be, wren and sel.
  - Matched -> ACCESS. Unmatched -> ERR.
  - bus_ready = 0.
- ACCESS:
  - slv_req[sel] = 1 and slv_wren[sel] = latched wren; all other slave bits = 0.
  - Wait counter increments each cycle.
  - If slv_ready[sel]=1: register slv_rddata[sel] (reads only; writes leave bus_rddata unchanged), then -> RESP.
  - Else if counter == TIMEOUT-1: -> ERR (slv_req drops on the next cycle).
  - slv_ready on non-selected slaves is ignored.
- RESP:
  - bus_ready = 1, bus_err = 0 for exactly one cycle, then -> IDLE.
- ERR:
  - bus_ready = 1, bus_err = 1, bus_rddata = ERR_RDDATA for one cycle, then -> IDLE.
- Latency:
  - Zero-wait slave: req seen in cycle 0, ACCESS in cycle 1, bus_ready in cycle 2.
  - Each wait state adds one cycle.
  - Decode error: bus_ready in cycle 1.
- Back-to-back: a new request is accepted only in IDLE, so throughput is one transaction per 3 cycles minimum.
- Protocol rules:
  - bus_req dropping mid-transaction does not abort it; the response is still issued.
  - Master inputs are sampled only in IDLE; later changes are ignored.
  - bus_be = 0 is still forwarded as a zero-byte access.
- bus_rddata holds its value between responses.

Decomposition:
- mem_pkg additions:
  - BUS_STATE_t enum (IDLE, ACCESS, RESP, ERR).
  - N_SLV_MAX = 8.
  - SLV_BASE / SLV_MASK constant arrays (ROM 0x0040_0000, RAM 0x1001_0000, GPIO, UART).
  - BUS_BE_t (4-bit).
- Sub-module bus_addr_decoder: combinational; takes bus_addr and returns match, sel index and word offset. It is reused by the future DMA master.

Test Plan:
- Read ROM 0x0040_0008, zero wait, slave0 returns 0x1234_5678 -> slv_addr=2, slv_req=0001; bus_ready at cycle 2 with bus_rddata=0x1234_5678, bus_err=0.
- Write RAM 0x1001_0010, be=4'b0011, data 0xAABB_CCDD, 3 wait states -> slv_wren[1]=1, slv_be=0011, slv_addr=4; bus_ready at cycle 5; bus_rddata unchanged.
- Access unmapped 0x2000_0000 -> bus_ready and bus_err at cycle 1, bus_rddata=0; slv_req stays 0.
- Selected slave never asserts ready, TIMEOUT=16 -> slv_req high for 16 cycles, then an error response; a non-selected slv_ready pulse during the wait is ignored.
- Assert rst during ACCESS -> slv_req=0 in the same cycle, no bus_ready; a new read after reset completes normally.
- Overlapping map entries 0 and 2 both match -> slave 0 selected; back-to-back reads complete at cycles 2 and 5.
